// File: rtl/multi_alarm_rtc.sv
// BCD real-time clock (12h/24h selectable at load) with NUM_ALARMS alarm slots,
// each carrying its own IDLE/RING/SNOOZE state machine.
module multi_alarm_rtc #(
    parameter int NUM_ALARMS   = 4,
    parameter int SEL_W        = 2,
    parameter int SNOOZE_S     = 300,
    parameter int RING_TIMEOUT = 60,
    parameter int SNOOZE_MAX   = 3
) (
    input  logic                  clk_1s,
    input  logic                  reset,
    input  logic                  tick_en,
    input  logic                  mode_24h,
    input  logic                  load_time,
    input  logic                  load_alarm,
    input  logic [SEL_W-1:0]      alarm_sel,
    input  logic [7:0]            hh_load,
    input  logic [7:0]            mm_load,
    input  logic [7:0]            ss_load,
    input  logic                  pm_load,
    input  logic [NUM_ALARMS-1:0] alarm_arm,
    input  logic                  snooze,
    input  logic                  alarm_stop,
    output logic [7:0]            hh,
    output logic [7:0]            mm,
    output logic [7:0]            ss,
    output logic                  pm,
    output logic [NUM_ALARMS-1:0] ringing,
    output logic [NUM_ALARMS-1:0] snoozed,
    output logic                  alarm_on,
    output logic                  load_err
);

    localparam int RING_W = $clog2(RING_TIMEOUT + 1);
    localparam int SNZ_W  = $clog2(SNOOZE_S + 1);
    localparam int CNT_W  = $clog2(SNOOZE_MAX + 1);
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_TIMEOUT - 1);
    localparam logic [SNZ_W-1:0]  SNZ_LOAD  = SNZ_W'(SNOOZE_S);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(SNOOZE_MAX);

    typedef enum logic [1:0] {S_IDLE, S_RING, S_SNOOZE} slot_state_e;

    function automatic logic bcd_ok(input logic [7:0] v, input int max);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) &&
               ((int'(v[7:4]) * 10 + int'(v[3:0])) <= max);
    endfunction

    function automatic logic hh_ok(input logic [7:0] v, input logic m24);
        if (m24) return bcd_ok(v, 23);
        return bcd_ok(v, 12) && (v != 8'h00);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    logic       mode_q, mode_d;
    logic [7:0] hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
    logic       pm_q, pm_d;
    logic       load_err_q;
    logic       time_err, alm_err, alm_load_ok, tick_adv;

    logic [7:0] alm_hh_q [NUM_ALARMS];
    logic [7:0] alm_mm_q [NUM_ALARMS];
    logic       alm_pm_q [NUM_ALARMS];

    always_comb begin
        mode_d   = mode_q;
        hh_d     = hh_q;
        mm_d     = mm_q;
        ss_d     = ss_q;
        pm_d     = pm_q;
        time_err = 1'b0;
        if (load_time) begin
            if (hh_ok(hh_load, mode_24h) && bcd_ok(mm_load, 59) && bcd_ok(ss_load, 59)) begin
                mode_d = mode_24h;
                hh_d   = hh_load;
                mm_d   = mm_load;
                ss_d   = ss_load;
                pm_d   = mode_24h ? (hh_load >= 8'h12) : pm_load;
            end else begin
                time_err = 1'b1;
            end
        end else if (tick_en) begin
            if (ss_q == 8'h59) begin
                ss_d = 8'h00;
                if (mm_q == 8'h59) begin
                    mm_d = 8'h00;
                    if (mode_q) begin
                        hh_d = (hh_q == 8'h23) ? 8'h00 : bcd_inc(hh_q);
                        pm_d = (hh_d >= 8'h12);
                    end else if (hh_q == 8'h12) begin
                        hh_d = 8'h01;
                    end else begin
                        hh_d = bcd_inc(hh_q);
                        // 11 -> 12 is where AM/PM flips, not 12 -> 1
                        if (hh_q == 8'h11) pm_d = ~pm_q;
                    end
                end else begin
                    mm_d = bcd_inc(mm_q);
                end
            end else begin
                ss_d = bcd_inc(ss_q);
            end
        end
    end

    // Alarm hours are validated against the mode in force before this edge.
    assign alm_load_ok = (int'(alarm_sel) < NUM_ALARMS) && hh_ok(hh_load, mode_q) &&
                         bcd_ok(mm_load, 59);
    assign alm_err     = load_alarm && !alm_load_ok;
    assign tick_adv    = tick_en && !load_time;

    always_ff @(posedge clk_1s) begin
        if (reset) begin
            mode_q     <= mode_24h;
            hh_q       <= mode_24h ? 8'h00 : 8'h12;
            mm_q       <= 8'h00;
            ss_q       <= 8'h00;
            pm_q       <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            hh_q       <= hh_d;
            mm_q       <= mm_d;
            ss_q       <= ss_d;
            pm_q       <= pm_d;
            load_err_q <= time_err | alm_err;
        end
    end

    always_ff @(posedge clk_1s) begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (reset) begin
                alm_hh_q[i] <= mode_24h ? 8'h00 : 8'h12;
                alm_mm_q[i] <= 8'h00;
                alm_pm_q[i] <= 1'b0;
            end else if (load_alarm && alm_load_ok && (alarm_sel == SEL_W'(i))) begin
                alm_hh_q[i] <= hh_load;
                alm_mm_q[i] <= mm_load;
                alm_pm_q[i] <= pm_load;
            end
        end
    end

    for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_slot
        slot_state_e       state_q;
        logic [RING_W-1:0] ring_cnt_q;
        logic [SNZ_W-1:0]  snz_tmr_q;
        logic [CNT_W-1:0]  snz_cnt_q;
        logic              match;

        assign match = tick_adv && alarm_arm[g] && (ss_d == 8'h00) &&
                       (mm_d == alm_mm_q[g]) && (hh_d == alm_hh_q[g]) &&
                       (mode_q || (pm_d == alm_pm_q[g]));

        always_ff @(posedge clk_1s) begin
            if (reset) begin
                state_q    <= S_IDLE;
                ring_cnt_q <= '0;
                snz_tmr_q  <= '0;
                snz_cnt_q  <= '0;
            end else if (!alarm_arm[g] || (load_alarm && (alarm_sel == SEL_W'(g)))) begin
                state_q <= S_IDLE;
            end else if (alarm_stop) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: if (match) begin
                        state_q    <= S_RING;
                        ring_cnt_q <= '0;
                        snz_cnt_q  <= '0;
                    end
                    S_RING: begin
                        if (snooze && (snz_cnt_q < CNT_MAX)) begin
                            state_q   <= S_SNOOZE;
                            snz_cnt_q <= snz_cnt_q + 1'b1;
                            snz_tmr_q <= SNZ_LOAD;
                        end else if (ring_cnt_q == RING_LAST) begin
                            state_q <= S_IDLE;
                        end else begin
                            ring_cnt_q <= ring_cnt_q + 1'b1;
                        end
                    end
                    S_SNOOZE: if (tick_en) begin
                        if (snz_tmr_q <= SNZ_W'(1)) begin
                            state_q    <= S_RING;
                            ring_cnt_q <= '0;
                        end else begin
                            snz_tmr_q <= snz_tmr_q - 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end

        assign ringing[g] = (state_q == S_RING);
        assign snoozed[g] = (state_q == S_SNOOZE);
    end

    assign hh       = hh_q;
    assign mm       = mm_q;
    assign ss       = ss_q;
    assign pm       = pm_q;
    assign alarm_on = |ringing;
    assign load_err = load_err_q;

endmodule
